// File: rtl/conv2_pkg.sv
// conv2_pkg: shared constants, state encoding, tag layout and the
// bias/ReLU/saturation helper for the layer-2 convolution sequencer.
package conv2_pkg;

  localparam int N_OCH   = 3;   // output channels = weight banks
  localparam int OUT_W   = 8;   // output columns per frame
  localparam int OUT_H   = 8;   // output rows per frame
  localparam int CALC_W  = 14;  // calc datapath result width (signed)
  localparam int BIAS_W  = 8;   // bias width (signed)
  localparam int ACT_W   = 12;  // activation width (unsigned)
  localparam int SUM_W   = 15;  // calc + bias without overflow
  localparam int ACT_MAX = 2047;

  localparam int SEL_W = 2;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // Negative sums clamp to 0, sums above ACT_MAX clamp to ACT_MAX.
  function automatic logic [ACT_W-1:0] relu_sat(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] lim;
    lim = SUM_W'(ACT_MAX);
    if (s[SUM_W-1]) begin
      return '0;
    end else if (s > lim) begin
      return ACT_W'(ACT_MAX);
    end else begin
      return s[ACT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/conv2_tag_pipe.sv
// conv2_tag_pipe: DEPTH-stage valid+tag delay line. A tag pushed alongside
// a calc issue emerges exactly DEPTH cycles later, aligned with calc_in.
// Ports:
//   clk, rst_n    clock, synchronous active-low clear of every stage
//   in_valid_i    issue strobe entering the line
//   in_tag_i      tag entering the line
//   out_valid_o   valid leaving the line
//   out_tag_o     tag leaving the line
module conv2_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  output logic [TAG_W-1:0] out_tag_o
);

  logic [DEPTH-1:0] vld_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid_i;
      tag_q[0] <= in_tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/conv2_sched.sv
// conv2_sched: time-multiplexes one shared 5x5x3 calc datapath across the
// N_OCH output channels of conv layer 2. Each window gets one calc per
// channel; results get the channel bias added, ReLU + saturation to 12 bits,
// and leave tagged with (ch,row,col). One frame is OUT_H x OUT_W windows.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               frame start pulse, honoured in IDLE only
//   win_valid/win_ack   window handshake from the line buffer
//   calc_en/calc_sel    issue strobe and weight bank to the calc datapath
//   calc_in             calc result, valid CALC_LAT cycles after calc_en
//   cfg_we/addr/data    bias write port, honoured in IDLE only
//   out_valid/data/ch/row/col  tagged activation to pooling
//   busy, frame_done    frame status
//   dbg_state           current FSM state (conv2_pkg::state_e encoding)
//
// Window handshake: the line buffer raises win_valid with a window present
// and holds it until win_ack. win_ack is high in the cycle of the last
// channel issue for that window; the buffer advances on that clock edge.
// The first issue of a window (calc_sel=0) happens combinationally in the
// WAIT cycle where win_valid is seen, so back-to-back windows have no bubble.
module conv2_sched
  import conv2_pkg::*;
#(
  parameter int CALC_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        win_valid,
  output logic        win_ack,
  output logic        calc_en,
  output logic [1:0]  calc_sel,
  input  logic [13:0] calc_in,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic        out_valid,
  output logic [11:0] out_data,
  output logic [1:0]  out_ch,
  output logic [2:0]  out_row,
  output logic [2:0]  out_col,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  // Drain counter must reach CALC_LAT+1.
  localparam int DRN_W = $clog2(CALC_LAT + 2);

  state_e state_q, state_d;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DRN_W-1:0] drain_q, drain_d;

  logic issue;
  logic ack;
  logic last_sel;
  logic last_win;
  logic drain_end;

  assign last_sel  = (sel_q == SEL_W'(N_OCH - 1));
  assign last_win  = (row_q == ROW_W'(OUT_H - 1)) && (col_q == COL_W'(OUT_W - 1));
  assign drain_end = (drain_q == DRN_W'(CALC_LAT + 1));

  // Issue happens in WAIT when a window is offered, and every ISSUE cycle
  // regardless of win_valid so that a started window always completes.
  assign issue = ((state_q == ST_WAIT) && win_valid) || (state_q == ST_ISSUE);
  assign ack   = issue && last_sel;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT;
      end
      ST_WAIT, ST_ISSUE: begin
        if (ack) begin
          state_d = last_win ? ST_DRAIN : ST_WAIT;
        end else if (issue) begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drain_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    calc_en    = issue;
    calc_sel   = sel_q;
    win_ack    = ack;
    frame_done = (state_q == ST_DRAIN) && drain_end;
    busy       = (state_q != ST_IDLE) && !frame_done;
    dbg_state  = state_q;
  end

  // ----------------------------------------------------------- counters
  always_comb begin
    sel_d   = sel_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = '0;
    if ((state_q == ST_IDLE) && start) begin
      sel_d = '0;
      row_d = '0;
      col_d = '0;
    end
    if (issue) begin
      sel_d = last_sel ? '0 : sel_q + 1'b1;
    end
    if (ack) begin
      if (col_q == COL_W'(OUT_W - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (state_q == ST_DRAIN) begin
      drain_d = drain_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
    end else begin
      sel_q   <= sel_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
    end
  end

  // ---------------------------------------------------------- bias file
  // Sized to the full address space so any tag indexes a real entry; only
  // the first N_OCH entries are writable.
  logic [BIAS_W-1:0] bias_q [2**SEL_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**SEL_W; i++) begin
        bias_q[i] <= '0;
      end
    end else if ((state_q == ST_IDLE) && cfg_we &&
                 ({1'b0, cfg_addr} < (SEL_W+1)'(N_OCH))) begin
      bias_q[cfg_addr] <= cfg_data;
    end
  end

  // ------------------------------------------------------- tag pipeline
  tag_t issue_tag;
  tag_t pipe_tag;
  logic pipe_vld;

  assign issue_tag = '{ch: sel_q, row: row_q, col: col_q};

  conv2_tag_pipe #(
    .DEPTH (CALC_LAT),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (issue),
    .in_tag_i    (issue_tag),
    .out_valid_o (pipe_vld),
    .out_tag_o   (pipe_tag)
  );

  // ------------------------------------------------------- output stage
  logic [BIAS_W-1:0]       bias_sel;
  logic signed [SUM_W-1:0] sum;

  assign bias_sel = bias_q[pipe_tag.ch];
  assign sum = $signed({{(SUM_W-CALC_W){calc_in[CALC_W-1]}}, calc_in}) +
               $signed({{(SUM_W-BIAS_W){bias_sel[BIAS_W-1]}}, bias_sel});

  logic             out_valid_q;
  logic [ACT_W-1:0] out_data_q;
  logic [SEL_W-1:0] out_ch_q;
  logic [ROW_W-1:0] out_row_q;
  logic [COL_W-1:0] out_col_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      out_valid_q <= pipe_vld;
      if (pipe_vld) begin
        out_data_q <= relu_sat(sum);
        out_ch_q   <= pipe_tag.ch;
        out_row_q  <= pipe_tag.row;
        out_col_q  <= pipe_tag.col;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv2_sched.sv
// tb_conv2_sched: randomized bench for conv2_sched with a window-level
// reference model (window index -> row/col, issue index -> channel, bias +
// clamp arithmetic) and an expected-output queue.
module tb_conv2_sched;

  localparam int LAT  = 1;
  localparam int NCH  = 3;
  localparam int NWIN = 64;
  localparam int FRAME_BUDGET = 4000;

  // ------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        win_valid = 1'b0;
  logic        win_ack;
  logic        calc_en;
  logic [1:0]  calc_sel;
  logic [13:0] calc_in = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        out_valid;
  logic [11:0] out_data;
  logic [1:0]  out_ch;
  logic [2:0]  out_row;
  logic [2:0]  out_col;
  logic        busy;
  logic        frame_done;
  logic [1:0]  dbg_state;

  conv2_sched #(.CALC_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .win_valid  (win_valid),
    .win_ack    (win_ack),
    .calc_en    (calc_en),
    .calc_sel   (calc_sel),
    .calc_in    (calc_in),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ------------------------------------------------------ model state
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bit frame_active = 1'b0;
  int start_cyc    = 0;
  int m_ch         = 0;  // issue index within the current window
  int m_win        = 0;  // completed windows in the current frame
  int n_out        = 0;
  int last_ack_cyc = 0;
  int val_mode     = 0;  // 0: const 100, 1: per-channel table, 2: random
  bit rst_seen     = 1'b0;
  bit last_ack     = 1'b0;

  logic signed [7:0] bias_m [NCH];
  logic [13:0]       hist [8];
  // {expected cycle[35:20], ch[19:18], row[17:15], col[14:12], data[11:0]}
  logic [35:0]       exp_q [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic logic signed [13:0] pick_val(input int ch);
    logic signed [13:0] v;
    case (val_mode)
      0: v = 14'sd100;
      1: v = (ch == 0) ? -14'sd3 : (ch == 1) ? 14'sd4 : 14'sd2040;
      default: v = 14'($urandom);
    endcase
    return v;
  endfunction

  function automatic int clamp_act(input int s);
    if (s < 0) return 0;
    if (s > 2047) return 2047;
    return s;
  endfunction

  // --------------------------------------------- monitor / scoreboard
  initial begin : monitor
    logic [35:0]        e;
    logic signed [13:0] v;
    logic [13:0]        issue_val;
    bit                 exp_en;
    int                 d;
    forever begin
      @(negedge clk);
      cyc++;
      issue_val = 14'($urandom);
      if (rst_seen) begin
        check("reset_outs", {out_valid, out_data, out_ch, out_row, out_col, calc_en,
                             calc_sel, win_ack, busy, frame_done, dbg_state}, '0);
      end else begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_cycle", 16'(cyc), e[35:20]);
            check("out_tag", {out_ch, out_row, out_col}, e[19:12]);
            check("out_data", out_data, e[11:0]);
            n_out++;
          end
        end
        exp_en = frame_active && (cyc > start_cyc) && (m_win < NWIN) &&
                 (win_valid || (m_ch != 0));
        check("calc_en", calc_en, exp_en);
        if (calc_en) begin
          check("calc_sel", calc_sel, m_ch);
          check("win_ack", win_ack, m_ch == NCH - 1);
          v = pick_val(m_ch);
          issue_val = v;
          d = clamp_act(int'(v) + int'(bias_m[m_ch % NCH]));
          exp_q.push_back({16'(cyc + LAT + 1), 2'(m_ch), 3'(m_win / 8), 3'(m_win % 8), 12'(d)});
          if (m_ch >= NCH - 1) begin
            m_ch = 0;
            m_win++;
            last_ack_cyc = cyc;
          end else begin
            m_ch++;
          end
        end else begin
          check("ack_no_issue", win_ack, 0);
        end
        last_ack = win_ack;
        check("frame_done", frame_done,
              frame_active && (m_win == NWIN) && (cyc == last_ack_cyc + LAT + 2));
        if (frame_done) begin
          check("frame_outs", n_out, NCH * NWIN);
          check("frame_acks", m_win, NWIN);
          check("drained", exp_q.size(), 0);
          frame_active = 1'b0;
        end
        check("busy", busy, frame_active && (cyc > start_cyc));
      end
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = issue_val;
      rst_seen = !rst_n;
      if (!rst_n) begin
        exp_q.delete();
        frame_active = 1'b0;
        m_ch  = 0;
        m_win = 0;
        n_out = 0;
        for (int i = 0; i < NCH; i++) bias_m[i] = '0;
      end
    end
  end

  // calc datapath stand-in: returns the value chosen at issue, LAT cycles on
  initial begin : calc_model
    forever begin
      @(posedge clk);
      #1;
      calc_in = hist[LAT-1];
    end
  end

  // ------------------------------------------------------ driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bias(input logic [1:0] addr, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    if (!frame_active && addr < NCH) bias_m[addr] = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_frame();
    start        = 1'b1;
    frame_active = 1'b1;
    start_cyc    = cyc + 1;
    n_out        = 0;
    m_ch         = 0;
    m_win        = 0;
    step();
    start = 1'b0;
  endtask

  // vmode 0: win_valid always high; 1: random, held until win_ack
  task automatic run_frame(input int vmode, input bit inject);
    int n;
    n = 0;
    while (frame_active && n < FRAME_BUDGET) begin
      if (vmode == 0) win_valid = 1'b1;
      else if (!win_valid || last_ack) win_valid = 1'($urandom_range(0, 1));
      if (inject && $urandom_range(0, 9) == 0) start = 1'b1;
      if (inject && $urandom_range(0, 9) == 0) begin
        cfg_we   = 1'b1;
        cfg_addr = 2'($urandom);
        cfg_data = 8'($urandom);
      end
      step();
      start  = 1'b0;
      cfg_we = 1'b0;
      n++;
    end
    if (frame_active) begin
      check("frame_timeout", 1, 0);
      frame_active = 1'b0;
    end
  endtask

  // ----------------------------------------------------------- stimulus
  initial begin : stim
    for (int k = 0; k < 8; k++) hist[k] = '0;
    for (int i = 0; i < NCH; i++) bias_m[i] = '0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // reset biases, constant input
    val_mode  = 0;
    win_valid = 1'b1;
    start_frame();
    run_frame(0, 1'b0);
    repeat (3) step();

    // bias add, ReLU clamp, saturation; addr 3 is not a bias
    write_bias(2'd0, 8'sd5);
    write_bias(2'd1, -8'sd5);
    write_bias(2'd2, 8'sd127);
    write_bias(2'd3, 8'sd99);
    val_mode = 1;
    start_frame();
    run_frame(0, 1'b0);
    repeat (2) step();

    // random biases and data, toggling win_valid, start/cfg during busy
    for (int i = 0; i < NCH; i++) write_bias(2'(i), 8'($urandom));
    val_mode  = 2;
    win_valid = 1'b0;
    start_frame();
    run_frame(1, 1'b1);
    repeat (4) step();

    // biases must be unchanged by the writes attempted while busy
    win_valid = 1'b1;
    start_frame();
    run_frame(0, 1'b0);
    step();

    // reset with issues in flight, then idle with windows offered
    start_frame();
    repeat ($urandom_range(30, 150)) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (20) step();

    // biases back to 0 after reset, random data and handshake
    win_valid = 1'b0;
    start_frame();
    run_frame(1, 1'b0);
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
